// File: rtl/riscv_mpsoc_pkg.sv
// Shared definitions for the PU-RISCV branch predictor: counter encodings,
// the BHT FSM state type and the saturating-counter training rule.
package riscv_mpsoc_pkg;

  // 2-bit saturating counter encodings; bit[1] set means predict taken.
  localparam logic [1:0] BP_SNT = 2'b00;
  localparam logic [1:0] BP_WNT = 2'b01;
  localparam logic [1:0] BP_WT  = 2'b10;
  localparam logic [1:0] BP_ST  = 2'b11;

  // BHT controller states: initialisation sweep, then normal operation.
  typedef enum logic {
    BP_FSM_INIT = 1'b0,
    BP_FSM_RUN  = 1'b1
  } bp_state_t;

  // Move the pipelined counter one step toward the resolved outcome,
  // saturating at strongly taken / strongly not-taken.
  function automatic logic [1:0] bp_train(input logic [1:0] predict,
                                          input logic       taken);
    logic [1:0] next_cnt;
    next_cnt = predict;
    if (taken) begin
      if (predict != BP_ST) next_cnt = predict + 2'd1;
    end else begin
      if (predict != BP_SNT) next_cnt = predict - 2'd1;
    end
    return next_cnt;
  endfunction

endpackage

// File: rtl/riscv_bp_ram.sv
// Simple 1-read/1-write synchronous RAM for the branch history table.
// Read data is registered (read-first); same-cycle bypass is handled by the
// caller so this stays a plain block-RAM template.
module riscv_bp_ram #(
  parameter int ADDR_BITS = 12,
  parameter int DATA_BITS = 2
) (
  input  logic                 clk,
  input  logic                 i_re,
  input  logic [ADDR_BITS-1:0] i_raddr,
  input  logic                 i_we,
  input  logic [ADDR_BITS-1:0] i_waddr,
  input  logic [DATA_BITS-1:0] i_wdata,
  output logic [DATA_BITS-1:0] o_rdata
);

  logic [DATA_BITS-1:0] r_mem [2**ADDR_BITS];
  logic [DATA_BITS-1:0] r_rdata;

  // Write port and registered read port.
  // NOTE: the array has no reset so it maps onto block RAM; the controller's
  // initialisation sweep gives every entry a defined value instead.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/riscv_bp.sv
// Branch history table (gselect) for the PU-RISCV core. Looks up a 2-bit
// counter per fetch PC with one cycle of latency and trains counters from the
// branch unit. After reset every entry is swept to weakly not-taken.
module riscv_bp
  import riscv_mpsoc_pkg::*;
#(
  parameter int XLEN              = 64,
  parameter int BP_GLOBAL_BITS    = 2,
  parameter int BP_LOCAL_BITS     = 10,
  parameter int BP_LOCAL_BITS_LSB = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      id_stall,
  input  logic [XLEN-1:0]           if_parcel_pc,
  output logic [1:0]                bp_bp_predict,
  output logic                      bp_init_busy,
  input  logic [XLEN-1:0]           ex_pc,
  input  logic [BP_GLOBAL_BITS-1:0] bu_bp_history,
  input  logic [1:0]                bu_bp_predict,
  input  logic                      bu_bp_btaken,
  input  logic                      bu_bp_update
);

  localparam int IDX_BITS = BP_GLOBAL_BITS + BP_LOCAL_BITS;
  localparam int PC_MSB   = BP_LOCAL_BITS + BP_LOCAL_BITS_LSB - 1;

  bp_state_t           r_state;
  bp_state_t           w_state_nxt;
  logic [IDX_BITS-1:0] r_init_idx;

  logic [IDX_BITS-1:0] w_ridx;
  logic [IDX_BITS-1:0] w_tidx;
  logic                w_we;
  logic [IDX_BITS-1:0] w_waddr;
  logic [1:0]          w_wdata;
  logic [1:0]          w_ram_q;

  logic                r_force;
  logic                r_byp_hit;
  logic [1:0]          r_byp_data;

  // Only the indexed PC slice matters; the remaining PC bits are deliberately
  // ignored and folded here so they are visibly accounted for.
  logic w_unused;
  assign w_unused = ^{if_parcel_pc, ex_pc};

  // gselect: global history concatenated above the PC slice. The current
  // history is used for lookups even though it may differ from train time.
  assign w_ridx = {bu_bp_history, if_parcel_pc[PC_MSB:BP_LOCAL_BITS_LSB]};
  assign w_tidx = {bu_bp_history, ex_pc[PC_MSB:BP_LOCAL_BITS_LSB]};

  // FSM state and sweep counter; reset restarts the sweep from entry 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= BP_FSM_INIT;
      r_init_idx <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == BP_FSM_INIT) r_init_idx <= r_init_idx + 1'b1;
    end
  end

  // Next state and table write port: sweep writes during INIT, training in RUN.
  // NOTE: every signal gets a default before the case so no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_we        = 1'b0;
    w_waddr     = w_tidx;
    w_wdata     = bp_train(bu_bp_predict, bu_bp_btaken);
    case (r_state)
      BP_FSM_INIT: begin
        w_we    = 1'b1;
        w_waddr = r_init_idx;
        w_wdata = BP_WNT;
        if (&r_init_idx) w_state_nxt = BP_FSM_RUN;
      end
      BP_FSM_RUN: begin
        w_we = bu_bp_update;
      end
      default: w_state_nxt = BP_FSM_INIT;
    endcase
  end

  riscv_bp_ram #(
    .ADDR_BITS (IDX_BITS),
    .DATA_BITS (2)
  ) u_ram (
    .clk     (clk),
    .i_re    (~id_stall),
    .i_raddr (w_ridx),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (w_wdata),
    .o_rdata (w_ram_q)
  );

  // Output-side qualifiers: force WNT for lookups issued during the sweep and
  // capture same-cycle write data for a write-first bypass. Held on stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_force    <= 1'b1;
      r_byp_hit  <= 1'b0;
      r_byp_data <= BP_WNT;
    end else if (!id_stall) begin
      r_force    <= (r_state == BP_FSM_INIT);
      r_byp_hit  <= w_we && (w_waddr == w_ridx);
      r_byp_data <= w_wdata;
    end
  end

  assign bp_bp_predict = r_force   ? BP_WNT     :
                         r_byp_hit ? r_byp_data : w_ram_q;
  assign bp_init_busy  = (r_state == BP_FSM_INIT);

endmodule

// File: tb/tb_riscv_bp.sv
// Self-checking bench for riscv_bp: directed scenarios plus randomized
// training/lookup traffic compared against an array model of the table.
module tb_riscv_bp;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_stall;
  logic [63:0] if_parcel_pc;
  logic [1:0]  bp_bp_predict;
  logic        bp_init_busy;
  logic [63:0] ex_pc;
  logic [1:0]  bu_bp_history;
  logic [1:0]  bu_bp_predict;
  logic        bu_bp_btaken;
  logic        bu_bp_update;

  int n_cmp = 0;
  int n_bad = 0;
  int model [4096];
  logic [1:0] last_pred;

  always #5 clk = ~clk;

  riscv_bp dut (
    .clk           (clk),
    .rst           (rst),
    .id_stall      (id_stall),
    .if_parcel_pc  (if_parcel_pc),
    .bp_bp_predict (bp_bp_predict),
    .bp_init_busy  (bp_init_busy),
    .ex_pc         (ex_pc),
    .bu_bp_history (bu_bp_history),
    .bu_bp_predict (bu_bp_predict),
    .bu_bp_btaken  (bu_bp_btaken),
    .bu_bp_update  (bu_bp_update)
  );

  // Table index from the gselect rule: history * 1024 + PC[11:2].
  function automatic int idx(input logic [63:0] pc, input logic [1:0] h);
    return int'(h) * 1024 + int'((pc >> 2) & 64'h3ff);
  endfunction

  // Saturating counter update expressed as clamped arithmetic.
  function automatic int train_model(input logic [1:0] pred, input logic tk);
    int v;
    v = tk ? int'(pred) + 1 : int'(pred) - 1;
    if (v > 3) v = 3;
    if (v < 0) v = 0;
    return v;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 4096; i++) model[i] = 1;
    last_pred = 2'b01;
  endtask

  task automatic idle_inputs();
    id_stall      = 1'b0;
    bu_bp_update  = 1'b0;
    bu_bp_predict = 2'b00;
    bu_bp_btaken  = 1'b0;
  endtask

  // One clock cycle: drive a lookup (and optional training write), update the
  // model write-first, then sample the prediction after the edge.
  task automatic step(input logic [63:0] pc, input logic [1:0] hist,
                      input logic [63:0] xpc, input logic upd,
                      input logic [1:0] pred, input logic tk, input logic stall,
                      output logic [1:0] exp, output logic [1:0] obs);
    if_parcel_pc  = pc;
    bu_bp_history = hist;
    ex_pc         = xpc;
    bu_bp_update  = upd;
    bu_bp_predict = pred;
    bu_bp_btaken  = tk;
    id_stall      = stall;
    if (upd && !bp_init_busy) model[idx(xpc, hist)] = train_model(pred, tk);
    exp = stall ? last_pred : 2'(model[idx(pc, hist)]);
    @(posedge clk); #1;
    obs = bp_bp_predict;
    last_pred = exp;
    idle_inputs();
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Counts edges after reset release until busy drops; -1 if it never does.
  task automatic run_sweep(output int n, output int forced_bad);
    n = -1;
    forced_bad = 0;
    for (int k = 1; k <= 6000; k++) begin
      @(posedge clk); #1;
      if (!bp_init_busy) begin
        n = k;
        break;
      end
      if (bp_bp_predict !== 2'b01) forced_bad++;
    end
    model_clear();
  endtask

  task automatic test_reset();
    int n, fb;
    idle_inputs();
    if_parcel_pc = 64'h8000_0000; ex_pc = 64'h0; bu_bp_history = 2'b00;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (bp_bp_predict !== 2'b01) begin
      n_bad++; $display("FAIL reset_predict: got %b want 01", bp_bp_predict);
    end
    n_cmp++;
    if (bp_init_busy !== 1'b1) begin
      n_bad++; $display("FAIL reset_busy: got %b want 1", bp_init_busy);
    end
    rst = 1'b0;
    run_sweep(n, fb);
    n_cmp++;
    if (n != 4096) begin
      n_bad++; $display("FAIL sweep_length: got %0d want 4096", n);
    end
    n_cmp++;
    if (fb != 0) begin
      n_bad++; $display("FAIL sweep_forced: %0d cycles not 01, want 0", fb);
    end
  endtask

  task automatic test_init_values();
    logic [1:0] e, o;
    int bad = 0;
    for (int h = 0; h < 4; h++)
      for (int l = 0; l < 1024; l++) begin
        step(64'(l) << 2, 2'(h), 64'h0, 1'b0, 2'b00, 1'b0, 1'b0, e, o);
        n_cmp++;
        if (o !== 2'b01) begin
          n_bad++;
          if (bad++ < 5) $display("FAIL init_value h=%0d l=%0d: got %b want 01", h, l, o);
        end
      end
  endtask

  task automatic test_train_taken();
    logic [1:0] e, o;
    logic [63:0] pc = 64'h8000_0010;
    logic [1:0] preds [3] = '{2'b01, 2'b10, 2'b11};
    logic [1:0] wants [3] = '{2'b10, 2'b11, 2'b11};
    for (int i = 0; i < 3; i++) begin
      step(64'h0, 2'b00, pc, 1'b1, preds[i], 1'b1, 1'b0, e, o);
      step(pc, 2'b00, 64'h0, 1'b0, 2'b00, 1'b0, 1'b0, e, o);
      n_cmp++;
      if (o !== wants[i]) begin
        n_bad++; $display("FAIL train_taken from %b: got %b want %b", preds[i], o, wants[i]);
      end
    end
  endtask

  task automatic test_train_not_taken_history();
    logic [1:0] e, o;
    logic [63:0] pc = 64'h8000_0010;
    step(64'h0, 2'b00, pc, 1'b1, 2'b00, 1'b0, 1'b0, e, o);
    step(pc, 2'b00, 64'h0, 1'b0, 2'b00, 1'b0, 1'b0, e, o);
    n_cmp++;
    if (o !== 2'b00) begin
      n_bad++; $display("FAIL train_nt_floor: got %b want 00", o);
    end
    step(pc, 2'b01, 64'h0, 1'b0, 2'b00, 1'b0, 1'b0, e, o);
    n_cmp++;
    if (o !== 2'b01) begin
      n_bad++; $display("FAIL history_isolation: got %b want 01", o);
    end
  endtask

  task automatic test_bypass();
    logic [1:0] e, o;
    logic [63:0] pc = 64'h8000_0200;
    step(pc, 2'b10, pc, 1'b1, 2'b10, 1'b1, 1'b0, e, o);
    n_cmp++;
    if (o !== 2'b11) begin
      n_bad++; $display("FAIL bypass_same_cycle: got %b want 11", o);
    end
    step(pc, 2'b10, 64'h0, 1'b0, 2'b00, 1'b0, 1'b0, e, o);
    n_cmp++;
    if (o !== 2'b11) begin
      n_bad++; $display("FAIL bypass_persist: got %b want 11", o);
    end
  endtask

  task automatic test_stall();
    logic [1:0] e, o;
    logic [63:0] pc_a = 64'h8000_0200;
    logic [63:0] pc_b = 64'h8000_0100;
    step(pc_a, 2'b10, 64'h0, 1'b0, 2'b00, 1'b0, 1'b0, e, o);
    n_cmp++;
    if (o !== 2'b11) begin
      n_bad++; $display("FAIL stall_pre: got %b want 11", o);
    end
    for (int i = 0; i < 3; i++) begin
      step(64'h8000_0040 + 64'(i * 4), 2'b00, pc_b, (i == 1), 2'b01, 1'b1, 1'b1, e, o);
      n_cmp++;
      if (o !== 2'b11) begin
        n_bad++; $display("FAIL stall_hold cycle %0d: got %b want 11", i, o);
      end
    end
    step(pc_b, 2'b00, 64'h0, 1'b0, 2'b00, 1'b0, 1'b0, e, o);
    n_cmp++;
    if (o !== 2'b10) begin
      n_bad++; $display("FAIL stall_train_visible: got %b want 10", o);
    end
  endtask

  task automatic test_random();
    logic [1:0] e, o;
    logic [63:0] pc, xpc;
    int bad = 0;
    for (int i = 0; i < 600; i++) begin
      pc  = 64'h8000_0000 + (64'($urandom_range(0, 15)) << 2);
      xpc = ($urandom_range(0, 3) == 0) ? pc
            : 64'h8000_0000 + (64'($urandom_range(0, 15)) << 2);
      step(pc, 2'($urandom_range(0, 3)), xpc, 1'($urandom_range(0, 1)),
           2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 7) == 0), e, o);
      n_cmp++;
      if (o !== e) begin
        n_bad++;
        if (bad++ < 5) $display("FAIL random cycle %0d: got %b want %b", i, o, e);
      end
    end
  endtask

  task automatic test_reset_midsweep();
    logic [1:0] e, o;
    int n, fb;
    logic [63:0] pc = 64'h8000_0300;
    step(64'h0, 2'b00, pc, 1'b1, 2'b10, 1'b1, 1'b0, e, o);
    step(pc, 2'b00, 64'h0, 1'b0, 2'b00, 1'b0, 1'b0, e, o);
    n_cmp++;
    if (o !== 2'b11) begin
      n_bad++; $display("FAIL midsweep_pretrain: got %b want 11", o);
    end
    pulse_reset();
    repeat (2000) @(posedge clk);
    #1;
    n_cmp++;
    if (bp_init_busy !== 1'b1) begin
      n_bad++; $display("FAIL midsweep_busy: got %b want 1", bp_init_busy);
    end
    pulse_reset();
    run_sweep(n, fb);
    n_cmp++;
    if (n != 4096) begin
      n_bad++; $display("FAIL midsweep_length: got %0d want 4096", n);
    end
    step(pc, 2'b00, 64'h0, 1'b0, 2'b00, 1'b0, 1'b0, e, o);
    n_cmp++;
    if (o !== 2'b01) begin
      n_bad++; $display("FAIL midsweep_entry_reinit: got %b want 01", o);
    end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_init_values();
    test_train_taken();
    test_train_not_taken_history();
    test_bypass();
    test_stall();
    test_random();
    test_reset_midsweep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
